boot_loader: RTL
================

// Module: boot_loader
// PURPOSE
//  Byte-stream program loader and run controller for SingleCycleCPU.
//  Receives a length-prefixed image over a valid/ready byte port, packs bytes
//  into little-endian 32-bit words and writes them to instruction memory.
//  After the last write it asserts cpu_start, which drives the CPU 'start' input.
//  Sits between the host/UART byte source and the CPU/imem at top level.
// PARAMETERS
//  ADDR_W     10    imem word-address width
//  MAX_WORDS  1024  largest accepted image length, in words
//  BASE_ADDR  0     word address of the first instruction written
// PORTS
//  clk         in   1       system clock; all logic on posedge
//  rst         in   1       synchronous reset, active-high
//  rx_data     in   8       image byte
//  rx_valid    in   1       rx_data is valid
//  rx_ready    out  1       loader accepts a byte; transfer = rx_valid & rx_ready
//  imem_we     out  1       one-cycle imem write strobe
//  imem_addr   out  ADDR_W  imem word address
//  imem_wdata  out  32      imem write word
//  cpu_start   out  1       CPU run enable (0 = CPU held), wired to CPU 'start'
//  busy        out  1       load in progress
//  done        out  1       image loaded, CPU running
//  err         out  1       image rejected; sticky until rst
// BEHAVIOUR
//  - Reset values: rx_ready=0, imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0,
//    cpu_start=0, busy=0, done=0, err=0. State=LEN0 on the cycle after rst drops.
//  - Frame format: LEN lo byte, LEN hi byte (16-bit word count N), then 4*N
//    payload bytes, LSB-first per word; optional checksum byte (see CONFIG).
//  - States: LEN0 -> LEN1 -> DATA -> [CHK] -> RUN; any -> ERR on error.
//  - LEN0/LEN1/DATA/CHK: rx_ready=1, busy=1. RUN/ERR: rx_ready=0, busy=0.
//  - LEN1 transfer: N==0 -> RUN (or CHK); N>MAX_WORDS -> ERR; else -> DATA.
//  - DATA: 2-bit byte counter; 4th byte of a word completes it. Next cycle:
//    imem_we=1 for exactly one cycle, imem_addr=BASE_ADDR+word_idx,
//    imem_wdata={b3,b2,b1,b0}. Byte acceptance continues without stall.
//  - Last word written: RUN entered the cycle after the final imem_we
//    (cpu_start never high while imem_we is high).
//  - RUN: cpu_start=1, done=1, held until rst. Further rx bytes ignored.
//  - ERR: err=1, cpu_start=0, no further imem writes, until rst.
//  - rx_valid gaps at any point: state/counters hold; no timeout.
//  - rst mid-load: all outputs to reset values next edge; partially written
//    imem contents are NOT cleared; a fresh frame is then expected.
//  - word_idx width ADDR_W+1; BASE_ADDR+word_idx truncates to ADDR_W (wraps).
// CONFIGURATION
//  BOOT_CHECKSUM_EN defined: after the last payload byte (or after LEN when
//   N==0) state CHK accepts one byte; it must equal XOR of all payload bytes
//   (0x00 for N==0). Match -> RUN; mismatch -> ERR.
//  BOOT_CHECKSUM_EN undefined: no CHK state; RUN follows directly.
// TESTING
//  1 N=2: 02 00 13 05 A0 00 93 05 10 00 -> imem[0]=00A00513, imem[1]=00100593,
//    two single-cycle strobes; cpu_start=1 one cycle after 2nd strobe.
//  2 N=0: 00 00 -> no imem_we; cpu_start=1 one cycle after 2nd byte accepted.
//  3 N=0x0401 (MAX_WORDS=1024): 01 04 -> err=1, rx_ready=0, no writes, start=0.
//  4 Case 1 with rx_valid low every other cycle -> identical writes/values.
//  5 Case 1 with rst pulsed after 5th byte -> all outputs reset, cpu_start=0;
//    then full case 1 frame -> same result as case 1.
//  6 BOOT_CHECKSUM_EN, case 1 + byte 30 -> RUN; + byte 31 -> err=1, start=0.

Source files
------------

// File: rtl/boot_loader.sv
// boot_loader: byte-stream program loader and run controller.
//
// Receives a length-prefixed image over a valid/ready byte port, packs the
// payload into little-endian 32-bit words, writes them to instruction memory
// and then releases the CPU through cpu_start.
//
// Frame: LEN lo, LEN hi (16-bit word count N), then 4*N payload bytes with
// each word sent LSB first.
//
// Build option: define BOOT_CHECKSUM_EN to require one trailing checksum byte
// equal to the XOR of all payload bytes (0x00 for an empty image). A mismatch
// rejects the image.
//
// All outputs are registered. Reset is synchronous and active-high.

module boot_loader #(
    parameter int ADDR_W    = 10,
    parameter int MAX_WORDS = 1024,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_start,
    output logic              busy,
    output logic              done,
    output logic              err
);

    // S_LAST holds the port closed for the single cycle in which the final
    // write strobe is on the bus. RUN therefore starts one cycle later, and
    // cpu_start never overlaps imem_we.
    typedef enum logic [2:0] {
        S_LEN0,
        S_LEN1,
        S_DATA,
        S_LAST,
        S_CHK,
        S_RUN,
        S_ERR
    } state_t;

    localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE_ADDR);

    state_t            state;
    logic [7:0]        len_lo;      // LEN low byte, held until the high byte
    logic [15:0]       len;         // image length in words
    logic [ADDR_W:0]   word_idx;    // words written so far
    logic [1:0]        byte_cnt;    // byte position inside the current word
    logic [7:0]        b0, b1, b2;  // first three bytes of the current word
`ifdef BOOT_CHECKSUM_EN
    logic [7:0]        csum;        // running XOR of the payload bytes
`endif

    // Byte transfer handshake.
    logic xfer;
    assign xfer = rx_valid & rx_ready;

    // Full length as it arrives with the high byte.
    logic [15:0] len_rx;
    assign len_rx = {rx_data, len_lo};

    // Oversize images are rejected. The compare is done at 32 bits so that
    // MAX_WORDS values up to and above 0xFFFF behave correctly.
    logic len_too_big;
    assign len_too_big = {16'd0, len_rx} > 32'(MAX_WORDS);

    // The word now being completed is the last word of the image.
    logic [15:0] word_next;
    logic        last_word;
    assign word_next = 16'(word_idx) + 16'd1;
    assign last_word = (word_next == len);

    // Frame parser FSM with registered handshake, write and status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: all state uses non-blocking assignments. Every register
            // then updates from values sampled at the same clock edge, with
            // no dependence on the order of the statements.
            state      <= S_LEN0;
            rx_ready   <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= BASE_A;
            imem_wdata <= 32'd0;
            cpu_start  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            len_lo     <= 8'd0;
            len        <= 16'd0;
            word_idx   <= '0;
            byte_cnt   <= 2'd0;
            b0         <= 8'd0;
            b1         <= 8'd0;
            b2         <= 8'd0;
`ifdef BOOT_CHECKSUM_EN
            csum       <= 8'd0;
`endif
        end else begin
            // NOTE: the strobe defaults low every cycle. Only the branch that
            // completes a word raises it, so a strobe lasts exactly one cycle.
            imem_we <= 1'b0;

            case (state)
                S_LEN0: begin
                    // The port opens on the first cycle after reset.
                    rx_ready <= 1'b1;
                    busy     <= 1'b1;
                    if (xfer) begin
                        len_lo <= rx_data;
                        state  <= S_LEN1;
                    end
                end

                S_LEN1: begin
                    if (xfer) begin
                        len      <= len_rx;
                        word_idx <= '0;
                        byte_cnt <= 2'd0;
`ifdef BOOT_CHECKSUM_EN
                        csum     <= 8'd0;
`endif
                        if (len_too_big) begin
                            state    <= S_ERR;
                            err      <= 1'b1;
                            rx_ready <= 1'b0;
                            busy     <= 1'b0;
                        end else if (len_rx == 16'd0) begin
`ifdef BOOT_CHECKSUM_EN
                            state     <= S_CHK;
`else
                            state     <= S_RUN;
                            cpu_start <= 1'b1;
                            done      <= 1'b1;
                            rx_ready  <= 1'b0;
                            busy      <= 1'b0;
`endif
                        end else begin
                            state <= S_DATA;
                        end
                    end
                end

                S_DATA: begin
                    if (xfer) begin
`ifdef BOOT_CHECKSUM_EN
                        csum     <= csum ^ rx_data;
`endif
                        byte_cnt <= byte_cnt + 2'd1;
                        case (byte_cnt)
                            2'd0: b0 <= rx_data;
                            2'd1: b1 <= rx_data;
                            2'd2: b2 <= rx_data;
                            default: begin
                                // Fourth byte: the write is issued on the
                                // next cycle while bytes keep arriving.
                                imem_we    <= 1'b1;
                                imem_addr  <= BASE_A + word_idx[ADDR_W-1:0];
                                imem_wdata <= {rx_data, b2, b1, b0};
                                word_idx   <= word_idx + (ADDR_W + 1)'(1);
                                if (last_word) begin
`ifdef BOOT_CHECKSUM_EN
                                    state    <= S_CHK;
`else
                                    state    <= S_LAST;
                                    rx_ready <= 1'b0;
`endif
                                end
                            end
                        endcase
                    end
                end

                S_LAST: begin
                    // The final strobe is on the bus now. Release the CPU
                    // on the next cycle.
                    state     <= S_RUN;
                    cpu_start <= 1'b1;
                    done      <= 1'b1;
                    rx_ready  <= 1'b0;
                    busy      <= 1'b0;
                end

`ifdef BOOT_CHECKSUM_EN
                S_CHK: begin
                    // This byte can arrive while the final strobe is still
                    // high. cpu_start rises only after the strobe has dropped.
                    if (xfer) begin
                        rx_ready <= 1'b0;
                        busy     <= 1'b0;
                        if (rx_data == csum) begin
                            state     <= S_RUN;
                            cpu_start <= 1'b1;
                            done      <= 1'b1;
                        end else begin
                            state <= S_ERR;
                            err   <= 1'b1;
                        end
                    end
                end
`endif

                S_RUN: begin
                    // The CPU runs until reset. Further bytes are ignored.
                    cpu_start <= 1'b1;
                    done      <= 1'b1;
                    rx_ready  <= 1'b0;
                    busy      <= 1'b0;
                end

                S_ERR: begin
                    // Sticky rejection: no writes and no CPU start.
                    err       <= 1'b1;
                    cpu_start <= 1'b0;
                    rx_ready  <= 1'b0;
                    busy      <= 1'b0;
                end

                default: begin
                    // Unreachable encodings fail safe into the error state.
                    state     <= S_ERR;
                    err       <= 1'b1;
                    cpu_start <= 1'b0;
                    rx_ready  <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
